dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 256 x 16-bit data memory. It accepts load/store requests from the CPU MEM stage (port 0) and the debug/DMA loader (port 1). It grants one request at a time round-robin and drives the memory's read/write strobes, address and write data for exactly one cycle. It registers the read data and returns it with a one-cycle ack pulse.

---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the data memory. It serves two load/store
// ports one at a time: one IDLE cycle, then one ACCESS cycle, then one RESP cycle.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              op_we_q, op_we_d;
  logic              last_grant_q, last_grant_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              gnt_sel;

  // Under contention the port that did not win last time is chosen.
  always_comb begin
    if (req0 && req1) gnt_sel = ~last_grant_q;
    else              gnt_sel = req1;
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    op_we_d      = op_we_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          gnt_d        = gnt_sel;
          last_grant_d = gnt_sel;
          op_we_d      = gnt_sel ? we1 : we0;
          mem_addr_d   = gnt_sel ? addr1 : addr0;
          mem_wdata_d  = gnt_sel ? wdata1 : wdata0;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (!op_we_q) begin
          if (gnt_q) rdata1_d = mem_rdata;
          else       rdata0_d = mem_rdata;
        end
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gnt_q        <= 1'b0;
      op_we_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      op_we_q      <= op_we_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Strobes are decoded from registered state only.
  assign mem_read  = (state_q == StAccess) && !op_we_q;
  assign mem_write = (state_q == StAccess) && op_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of single transactions plus hand-written
// sequences for contention, back-to-back requests and reset during ACCESS.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic        mem_read, mem_write, busy;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] mem [256];

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read memory with synchronous write.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      chk("ack_exclusive", {31'b0, ack0 & ack1}, 32'd0);
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 0; req1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated transaction: ACCESS in cycle N+1, ack in cycle N+2, idle in N+3.
  task automatic do_txn(input vec_t v);
    if (v.port) begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    else        begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    @(negedge clk);
    chk("txn_access_busy", {31'b0, busy}, 32'd1);
    chk("txn_read_strobe", {31'b0, mem_read}, {31'b0, ~v.we});
    chk("txn_write_strobe", {31'b0, mem_write}, {31'b0, v.we});
    chk("txn_addr", {24'b0, mem_addr}, {24'b0, v.addr});
    if (v.we) chk("txn_wdata", {16'b0, mem_wdata}, {16'b0, v.wdata});
    chk("txn_no_early_ack", {30'b0, ack1, ack0}, 32'd0);
    @(negedge clk);
    chk("txn_ack", {30'b0, ack1, ack0}, v.port ? 32'd2 : 32'd1);
    chk("txn_resp_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("txn_resp_busy", {31'b0, busy}, 32'd1);
    chk("txn_rdata", {16'b0, v.port ? rdata1 : rdata0}, {16'b0, v.exp_rdata});
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("txn_idle_busy", {31'b0, busy}, 32'd0);
    chk("txn_ack_cleared", {30'b0, ack1, ack0}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = k[15:0];
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    vecs[0] = '{1'b0, 1'b0, 8'h05, 16'h0000, 16'h0005};
    vecs[1] = '{1'b1, 1'b1, 8'h10, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 8'h33, 16'hA5A5, 16'h0005};
    vecs[4] = '{1'b1, 1'b0, 8'h33, 16'h0000, 16'hA5A5};
    vecs[5] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'h00FF};
    vecs[6] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    vecs[7] = '{1'b1, 1'b1, 8'h10, 16'h0001, 16'hA5A5};

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_acks", {30'b0, ack1, ack0}, 32'd0);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
    chk("rst_rdata", {rdata1, rdata0}, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_no_req", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);
    chk("mem_final_10", {16'b0, mem[8'h10]}, 32'h0001);

    // Both ports requesting from reset: grants alternate starting with port 0.
    do_reset();
    req0 = 1; we0 = 0; addr0 = 8'h40;
    req1 = 1; we1 = 0; addr1 = 8'h41;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_addr", {24'b0, mem_addr}, (i % 2 == 0) ? 32'h40 : 32'h41);
      chk("rr_read", {31'b0, mem_read}, 32'd1);
      @(negedge clk);
      chk("rr_ack", {30'b0, ack1, ack0}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rdata", {16'b0, (i % 2 == 0) ? rdata0 : rdata1},
          (i % 2 == 0) ? 32'h40 : 32'h41);
      if (i == 3) begin req0 = 0; req1 = 0; end
      @(negedge clk);
      chk("rr_idle", {31'b0, busy}, 32'd0);
    end

    // Write from port 0 and read from port 1 contending on the same address.
    do_reset();
    req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 16'h1234;
    req1 = 1; we1 = 0; addr1 = 8'h20;
    @(negedge clk);
    chk("wr_first_write", {31'b0, mem_write}, 32'd1);
    @(negedge clk);
    chk("wr_first_ack0", {30'b0, ack1, ack0}, 32'd1);
    req0 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("wr_second_read", {31'b0, mem_read}, 32'd1);
    @(negedge clk);
    chk("wr_second_ack1", {30'b0, ack1, ack0}, 32'd2);
    chk("wr_rdata1", {16'b0, rdata1}, 32'h1234);
    req1 = 0;
    @(negedge clk);

    // Reset during the ACCESS cycle of a port 0 read drops the response.
    do_reset();
    req0 = 1; we0 = 0; addr0 = 8'h07;
    @(negedge clk);
    chk("rstmid_access", {31'b0, mem_read}, 32'd1);
    rst = 1; req0 = 0;
    @(negedge clk);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_ack", {30'b0, ack1, ack0}, 32'd0);
    chk("rstmid_rdata0", {16'b0, rdata0}, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("rstmid_no_late_ack", {30'b0, ack1, ack0}, 32'd0);
    do_txn('{1'b0, 1'b0, 8'h07, 16'h0000, 16'h0007});

    // req0 held continuously: one transaction every three cycles.
    req0 = 1; we0 = 0; addr0 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("seq_addr", {24'b0, mem_addr}, i);
      chk("seq_read", {31'b0, mem_read}, 32'd1);
      @(negedge clk);
      chk("seq_ack0", {30'b0, ack1, ack0}, 32'd1);
      chk("seq_rdata0", {16'b0, rdata0}, i);
      addr0 = 8'(i + 1);
      if (i == 2) req0 = 0;
      @(negedge clk);
      chk("seq_idle", {31'b0, busy}, 32'd0);
    end
    @(negedge clk);
    chk("seq_stopped", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
